serv_dbg_ibus: RTL and testbench

- Instruction-bus responder between the SERV core ibus and instruction memory.
- Normal operation: fetches pass through to memory unchanged.
- Debug mode: fetches that hit the program-buffer window are answered locally from a small debugger-writable program buffer.
- The fetch after the last buffer entry returns an implicit EBREAK, so the core re-enters its debug park loop.

---
 rtl/serv_dbg_ibus_if.sv | 29 ++
 rtl/serv_dbg_ibus.sv | 170 +++++++++++++++++
 tb/tb_serv_dbg_ibus.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_dbg_ibus_if.sv
// serv_dbg_ibus_if: the core-side fetch bus and the memory-side fetch bus
// that pass through the program-buffer responder.
interface serv_dbg_ibus_if;

  // Core-side fetch bus
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  // Memory-side fetch bus
  logic [31:0] o_mem_adr;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;

  // Responder view
  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_mem_rdt, i_mem_ack,
    output o_ibus_rdt, o_ibus_ack, o_mem_adr, o_mem_cyc
  );

  // Core/memory view
  modport master (
    output i_ibus_adr, i_ibus_cyc, i_mem_rdt, i_mem_ack,
    input  o_ibus_rdt, o_ibus_ack, o_mem_adr, o_mem_cyc
  );

endinterface

// File: rtl/serv_dbg_ibus.sv
// serv_dbg_ibus: instruction-bus responder for the SERV core.
// Normal fetches are forwarded to memory. In debug mode, fetches that land
// in the program-buffer window are answered from a local buffer, and the
// word just past the last entry returns an implicit EBREAK.
// Optional feature: define SERV_DBG_PB_READBACK_EN to add a registered
// program-buffer readback port (i_pb_re / o_pb_rdata).
module serv_dbg_ibus #(
  parameter logic [31:0] PB_BASE = 32'h0000_0800,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  serv_dbg_ibus_if.slave           bus,
  input  logic                     i_dbg_mode,
  input  logic                     i_pb_we,
  input  logic [$clog2(DEPTH)-1:0] i_pb_idx,
  input  logic [31:0]              i_pb_wdata,
`ifdef SERV_DBG_PB_READBACK_EN
  input  logic                     i_pb_re,
  output logic [31:0]              o_pb_rdata,
`endif
  output logic                     o_busy
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 3;
  localparam int unsigned OW = 30;

  localparam logic [31:0]   INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0]   INSN_EBREAK = 32'h0010_0073;
  localparam logic [OW-1:0] BASE_WORD   = PB_BASE[31:2];

  typedef enum logic [1:0] {
    IDLE,
    PB_WAIT,
    PB_ACK,
    MEM
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            busy_q;
  logic [31:0]     rdt_q;
  logic [31:0]     pb_q [DEPTH];

  logic [OW-1:0]   word_off_c;
  logic            hit_c;
  logic [31:0]     fetch_data_c;
  logic            cap_c;

  // Window decode: word offset from entry 0; unsigned wrap makes addresses
  // below the base miss, and the window spans DEPTH entries plus EBREAK.
  always_comb begin
    word_off_c   = bus.i_ibus_adr[31:2] - BASE_WORD;
    hit_c        = i_dbg_mode && (word_off_c <= OW'(DEPTH));
    fetch_data_c = INSN_EBREAK;
    if (word_off_c < OW'(DEPTH)) begin
      fetch_data_c = pb_q[word_off_c[IW-1:0]];
    end
  end

  // Next-state logic; routing is decided only in IDLE and then held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_ibus_cyc) begin
          if (hit_c) begin
            cap_c = 1'b1;
            cnt_d = CW'(LATENCY - 1);
            // A single-cycle latency acks in the very next cycle.
            state_d = (LATENCY == 1) ? PB_ACK : PB_WAIT;
          end else begin
            state_d = MEM;
          end
        end
      end
      PB_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = PB_ACK;
        end
      end
      PB_ACK: begin
        state_d = IDLE;
      end
      MEM: begin
        if (bus.i_mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, latency counter and busy flag.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Captured buffer-hit data; sampled before any same-cycle buffer write.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdt_q <= '0;
    end else if (cap_c) begin
      rdt_q <= fetch_data_c;
    end
  end

  // Program buffer storage, writable in every state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pb_q[i] <= INSN_NOP;
      end
    end else if (i_pb_we) begin
      pb_q[i_pb_idx] <= i_pb_wdata;
    end
  end

`ifdef SERV_DBG_PB_READBACK_EN
  logic [31:0] pb_rdata_q;

  // Registered readback; holds until the next read strobe.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pb_rdata_q <= '0;
    end else if (i_pb_re) begin
      pb_rdata_q <= pb_q[i_pb_idx];
    end
  end

  assign o_pb_rdata = pb_rdata_q;
`endif

  // Bus outputs; the memory path acks combinationally in the i_mem_ack cycle.
  always_comb begin
    bus.o_ibus_ack = 1'b0;
    bus.o_ibus_rdt = '0;
    bus.o_mem_cyc  = 1'b0;
    bus.o_mem_adr  = bus.i_ibus_adr;
    if (state_q == PB_ACK) begin
      bus.o_ibus_ack = 1'b1;
      bus.o_ibus_rdt = rdt_q;
    end else if (state_q == MEM) begin
      bus.o_mem_cyc  = 1'b1;
      bus.o_ibus_ack = bus.i_mem_ack;
      bus.o_ibus_rdt = bus.i_mem_ack ? bus.i_mem_rdt : '0;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: tb/tb_serv_dbg_ibus.sv
// tb_serv_dbg_ibus: randomized, self-checking bench for serv_dbg_ibus.
// Two instances: LATENCY=1 (sel 0) and LATENCY=3 (sel 1), sharing reset,
// debug-mode and program-buffer write inputs.
module tb_serv_dbg_ibus;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0800;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst_n;
  logic        dbg_mode;
  logic        pb_we;
  logic [1:0]  pb_idx;
  logic [31:0] pb_wdata;
  logic        busy1;
  logic        busy3;
`ifdef SERV_DBG_PB_READBACK_EN
  logic        pb_re;
  logic [31:0] rdata1;
  logic [31:0] rdata3;
`endif

  int checks;
  int errors;

  // Reference program-buffer contents.
  logic [31:0] pb_m [DEPTH];

  // Mid-fetch action: 0 none, 1 drop debug mode, 2 assert reset, 3 buffer write.
  int          act_kind;
  int          act_cyc;
  logic [1:0]  act_idx;
  logic [31:0] act_data;

  // Results of the last fetch.
  logic [31:0] f_rdt;
  int          f_ack;
  int          f_memc;
  logic        f_adr_ok;
  logic        f_clean;
  logic        f_busy_rst;

  serv_dbg_ibus_if bus1 ();
  serv_dbg_ibus_if bus3 ();

  serv_dbg_ibus #(.PB_BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .bus        (bus1),
    .i_dbg_mode (dbg_mode),
    .i_pb_we    (pb_we),
    .i_pb_idx   (pb_idx),
    .i_pb_wdata (pb_wdata),
`ifdef SERV_DBG_PB_READBACK_EN
    .i_pb_re    (pb_re),
    .o_pb_rdata (rdata1),
`endif
    .o_busy     (busy1)
  );

  serv_dbg_ibus #(.PB_BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) dut3 (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .bus        (bus3),
    .i_dbg_mode (dbg_mode),
    .i_pb_we    (pb_we),
    .i_pb_idx   (pb_idx),
    .i_pb_wdata (pb_wdata),
`ifdef SERV_DBG_PB_READBACK_EN
    .i_pb_re    (pb_re),
    .o_pb_rdata (rdata3),
`endif
    .o_busy     (busy3)
  );

  always #5 clk = ~clk;

  // Reference: which fetches the buffer answers and with what word.
  function automatic logic ref_hit(input logic [31:0] adr, input logic dbg);
    longint off;
    off = longint'(adr >> 2) - longint'(BASE >> 2);
    return dbg && off >= 0 && off <= DEPTH;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] adr);
    longint off;
    off = longint'(adr >> 2) - longint'(BASE >> 2);
    if (off == DEPTH) return EBREAK;
    return pb_m[int'(off)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pb_write(input logic [1:0] idx, input logic [31:0] data);
    pb_we = 1'b1; pb_idx = idx; pb_wdata = data;
    tick();
    pb_m[idx] = data;
    pb_we = 1'b0;
  endtask

  // One core fetch on the selected instance, with a memory model that acks
  // on the mem_lat-th cycle of o_mem_cyc. Cycle 0 is the first cyc-high cycle.
  task automatic fetch(input bit sel, input logic [31:0] adr, input int mem_lat,
                       input logic [31:0] mem_data);
    logic aborted;
    logic ack_s, mcyc_s;
    logic [31:0] rdt_s, madr_s;
    aborted = 1'b0;
    f_rdt = '0; f_ack = -1; f_memc = 0; f_adr_ok = 1'b1; f_clean = 1'b1; f_busy_rst = 1'b0;
    bus1.i_ibus_adr = adr; bus3.i_ibus_adr = adr;
    bus1.i_ibus_cyc = !sel; bus3.i_ibus_cyc = sel;
    for (int c = 0; c < 40; c++) begin
      if (act_kind == 1 && c == act_cyc) dbg_mode = 1'b0;
      if (act_kind == 3 && c == act_cyc) begin
        pb_we = 1'b1; pb_idx = act_idx; pb_wdata = act_data;
      end
      if (act_kind == 2 && c == act_cyc) begin
        rst_n = 1'b0; aborted = 1'b1;
        bus1.i_ibus_cyc = 1'b0; bus3.i_ibus_cyc = 1'b0;
        for (int i = 0; i < DEPTH; i++) pb_m[i] = NOP;
      end
      mcyc_s = sel ? bus3.o_mem_cyc : bus1.o_mem_cyc;
      bus1.i_mem_ack = mcyc_s && (f_memc + 1 == mem_lat);
      bus3.i_mem_ack = bus1.i_mem_ack;
      bus1.i_mem_rdt = bus1.i_mem_ack ? mem_data : $urandom;
      bus3.i_mem_rdt = bus1.i_mem_rdt;
      #1;
      ack_s  = sel ? bus3.o_ibus_ack : bus1.o_ibus_ack;
      rdt_s  = sel ? bus3.o_ibus_rdt : bus1.o_ibus_rdt;
      mcyc_s = sel ? bus3.o_mem_cyc  : bus1.o_mem_cyc;
      madr_s = sel ? bus3.o_mem_adr  : bus1.o_mem_adr;
      if (act_kind == 2 && c == act_cyc) f_busy_rst = sel ? busy3 : busy1;
      if (mcyc_s) begin
        f_memc++;
        if (madr_s !== adr) f_adr_ok = 1'b0;
      end
      if (ack_s === 1'b1) begin
        if (f_ack < 0) begin f_ack = c; f_rdt = rdt_s; end
        else f_clean = 1'b0;
      end else if (rdt_s !== 32'h0) begin
        f_clean = 1'b0;
      end
      @(posedge clk);
      #1;
      if (pb_we) begin pb_m[pb_idx] = pb_wdata; pb_we = 1'b0; end
      if (f_ack >= 0 && !aborted) break;
      if (aborted && c >= act_cyc + 8) break;
    end
    // Core drops cyc in the cycle after ack; no further ack may appear.
    bus1.i_ibus_cyc = 1'b0; bus3.i_ibus_cyc = 1'b0;
    bus1.i_mem_ack = 1'b0; bus3.i_mem_ack = 1'b0;
    bus1.i_ibus_adr = $urandom; bus3.i_ibus_adr = bus1.i_ibus_adr;
    #1;
    if ((sel ? bus3.o_ibus_ack : bus1.o_ibus_ack) !== 1'b0) f_clean = 1'b0;
    if ((sel ? bus3.o_ibus_rdt : bus1.o_ibus_rdt) !== 32'h0) f_clean = 1'b0;
    tick();
    act_kind = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus1.o_ibus_ack, bus1.o_mem_cyc, busy1, bus3.o_ibus_ack, bus3.o_mem_cyc, busy3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack/mcyc/busy %b%b%b %b%b%b expected all 0",
               bus1.o_ibus_ack, bus1.o_mem_cyc, busy1, bus3.o_ibus_ack, bus3.o_mem_cyc, busy3);
    end
    checks++;
    if (bus1.o_ibus_rdt !== 32'h0 || bus3.o_ibus_rdt !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdt: got %h %h expected 0", bus1.o_ibus_rdt, bus3.o_ibus_rdt);
    end
`ifdef SERV_DBG_PB_READBACK_EN
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", rdata1);
    end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) pb_m[i] = NOP;
    tick();
  endtask

  // Check the result of a fetch against the reference model.
  task automatic check_fetch(input string name, input bit sel, input logic [31:0] adr,
                             input logic dbg, input int mem_lat, input logic [31:0] mem_data,
                             input logic [31:0] exp_word);
    logic hit;
    int   exp_ack;
    hit = ref_hit(adr, dbg);
    exp_ack = hit ? (sel ? 3 : 1) : mem_lat;
    checks++;
    if (f_ack != exp_ack) begin
      errors++;
      $display("FAIL %s_ack_cycle: got %0d expected %0d (adr %h)", name, f_ack, exp_ack, adr);
    end
    checks++;
    if (f_rdt !== (hit ? exp_word : mem_data)) begin
      errors++;
      $display("FAIL %s_rdt: got %h expected %h (adr %h)", name, f_rdt, hit ? exp_word : mem_data, adr);
    end
    checks++;
    if (f_memc != (hit ? 0 : mem_lat) || !f_adr_ok) begin
      errors++;
      $display("FAIL %s_mem: got %0d mem cycles adr_ok %b expected %0d adr_ok 1",
               name, f_memc, f_adr_ok, hit ? 0 : mem_lat);
    end
    checks++;
    if (!f_clean) begin
      errors++;
      $display("FAIL %s_quiet: got stray ack or nonzero rdt outside ack expected none", name);
    end
  endtask

  task automatic test_pb_default();
    dbg_mode = 1'b1;
    fetch(0, BASE, 1, 32'h0);
    check_fetch("pb_default", 0, BASE, 1'b1, 1, 32'h0, NOP);
  endtask

  task automatic test_mem_pass();
    dbg_mode = 1'b0;
    fetch(0, BASE, 3, 32'hDEAD_BEEF);
    check_fetch("mem_pass", 0, BASE, 1'b0, 3, 32'hDEAD_BEEF, 32'h0);
  endtask

  task automatic test_window();
    pb_write(2'd1, 32'h7B00_22F3);
    dbg_mode = 1'b1;
    fetch(0, BASE + 32'h4, 1, 32'h0);
    check_fetch("win_pb1", 0, BASE + 32'h4, 1'b1, 1, 32'h0, 32'h7B00_22F3);
    fetch(0, BASE + 32'h10, 1, 32'h0);
    check_fetch("win_ebreak", 0, BASE + 32'h10, 1'b1, 1, 32'h0, EBREAK);
    fetch(0, BASE + 32'h14, 2, 32'hCAFE_0001);
    check_fetch("win_past", 0, BASE + 32'h14, 1'b1, 2, 32'hCAFE_0001, 32'h0);
    fetch(1, BASE - 32'h4, 1, 32'hCAFE_0002);
    check_fetch("win_below", 1, BASE - 32'h4, 1'b1, 1, 32'hCAFE_0002, 32'h0);
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] old;
    dbg_mode = 1'b1;
    old = pb_m[0];
    act_kind = 3; act_cyc = 0; act_idx = 2'd0; act_data = 32'h1234_5678;
    fetch(0, BASE, 1, 32'h0);
    check_fetch("same_wr_old", 0, BASE, 1'b1, 1, 32'h0, old);
    fetch(0, BASE, 1, 32'h0);
    check_fetch("same_wr_new", 0, BASE, 1'b1, 1, 32'h0, 32'h1234_5678);
    // A write while the slow instance is waiting must not disturb captured data.
    old = pb_m[2];
    act_kind = 3; act_cyc = 1; act_idx = 2'd2; act_data = 32'h0BAD_F00D;
    fetch(1, BASE + 32'h8, 1, 32'h0);
    check_fetch("wait_wr_old", 1, BASE + 32'h8, 1'b1, 1, 32'h0, old);
  endtask

  task automatic test_dbg_drop();
    logic [31:0] exp;
    pb_write(2'd2, 32'h00A0_0513);
    exp = pb_m[2];
    dbg_mode = 1'b1;
    act_kind = 1; act_cyc = 1;
    fetch(1, BASE + 32'h8, 1, 32'h0);
    check_fetch("dbg_drop", 1, BASE + 32'h8, 1'b1, 1, 32'h0, exp);
    dbg_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) pb_write(2'(i), $urandom);
    dbg_mode = 1'b1;
    act_kind = 2; act_cyc = 2;
    fetch(1, BASE, 1, 32'h0);
    checks++;
    if (f_ack != -1) begin
      errors++;
      $display("FAIL rst_mid_ack: got ack in cycle %0d expected none", f_ack);
    end
    checks++;
    if (f_busy_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: got %b expected 0", f_busy_rst);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      fetch(0, BASE + 32'(4 * i), 1, 32'h0);
      checks++;
      if (f_rdt !== NOP || f_ack != 1) begin
        errors++;
        $display("FAIL rst_mid_pb%0d: got %h at cycle %0d expected %h at cycle 1", i, f_rdt, f_ack, NOP);
      end
    end
  endtask

  task automatic test_random();
    bit          sel;
    logic        dbg;
    logic [31:0] adr, md, exp;
    int          lat, w;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) pb_write(2'($urandom_range(0, 3)), $urandom);
      sel = 1'($urandom_range(0, 1));
      dbg = 1'($urandom_range(0, 3) != 0);
      dbg_mode = dbg;
      if ($urandom_range(0, 9) < 8) begin
        w = int'($urandom_range(0, 7)) - 1;
        adr = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      end else begin
        adr = $urandom;
      end
      lat = int'($urandom_range(1, 4));
      md  = $urandom;
      exp = ref_hit(adr, dbg) ? ref_word(adr) : 32'h0;
      fetch(sel, adr, lat, md);
      check_fetch("rand", sel, adr, dbg, lat, md, exp);
    end
  endtask

`ifdef SERV_DBG_PB_READBACK_EN
  task automatic test_readback();
    logic [31:0] old;
    for (int i = 0; i < DEPTH; i++) begin
      pb_idx = 2'(i); pb_re = 1'b1;
      tick();
      pb_re = 1'b0;
      tick();
      checks++;
      if (rdata1 !== pb_m[i] || rdata3 !== pb_m[i]) begin
        errors++;
        $display("FAIL readback%0d: got %h %h expected %h", i, rdata1, rdata3, pb_m[i]);
      end
    end
    old = pb_m[1];
    pb_idx = 2'd1; pb_re = 1'b1; pb_we = 1'b1; pb_wdata = ~old;
    tick();
    pb_m[1] = ~old; pb_re = 1'b0; pb_we = 1'b0;
    checks++;
    if (rdata1 !== old) begin
      errors++;
      $display("FAIL readback_rw: got %h expected %h", rdata1, old);
    end
  endtask
`endif

  initial begin
    clk = 1'b0; rst_n = 1'b0; dbg_mode = 1'b0;
    pb_we = 1'b0; pb_idx = '0; pb_wdata = '0;
`ifdef SERV_DBG_PB_READBACK_EN
    pb_re = 1'b0;
`endif
    bus1.i_ibus_adr = '0; bus1.i_ibus_cyc = 1'b0; bus1.i_mem_rdt = '0; bus1.i_mem_ack = 1'b0;
    bus3.i_ibus_adr = '0; bus3.i_ibus_cyc = 1'b0; bus3.i_mem_rdt = '0; bus3.i_mem_ack = 1'b0;
    checks = 0; errors = 0; act_kind = 0; act_cyc = 0; act_idx = '0; act_data = '0;
    test_reset();
    test_pb_default();
    test_mem_pass();
    test_window();
    test_same_cycle_write();
    test_dbg_drop();
    test_reset_mid();
    test_random();
`ifdef SERV_DBG_PB_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
